perf_counter_unit: RTL
======================

Name: perf_counter_unit

Overview:
Synthesizable pipeline performance monitor for the pipelined CPU. It counts clock cycles and up to NUM_EVT per-cycle event strobes, such as stall, flush, retired instruction and branch taken. It supports a programmable cycle limit that halts measurement, and an atomic snapshot of all counters for readout. It is instantiated alongside the CPU core and generalises bench-side stall/flush counting into a reusable on-chip block with selectable width, channel count and overflow mode.

Parameters:
NUM_EVT, 4, number of event channels (1..16)
CNT_W, 32, width of each event counter and the cycle counter
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap modulo 2^CNT_W
SEL_W, $clog2(NUM_EVT) (minimum 1), width of the readout select

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  level; moves IDLE to RUN
event_i  in  NUM_EVT  per-cycle event strobes, sampled each rising edge
freeze_i  in  1  suspends all counting; state is unchanged
clear_i  in  1  synchronous clear of counters and overflow flags
snap_i  in  1  captures all live counters into shadow registers
limit_i  in  CNT_W  cycle limit; 0 = unlimited
sel_i  in  SEL_W  selects the shadow event counter driven on count_o
count_o  out  CNT_W  shadow[sel_i], combinational mux of registered shadows
snap_cycle_o  out  CNT_W  shadow cycle count
cycle_o  out  CNT_W  live cycle counter
snap_valid_o  out  1  one-cycle pulse after a snapshot is captured
halt_o  out  1  high while in HALTED
ovf_o  out  NUM_EVT  sticky overflow flag per channel

Behaviour:
- Reset (rst_i=0, asynchronous, effective immediately mid-operation): state=IDLE; all live counters, shadows, ovf_o, snap_valid_o and halt_o = 0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on any edge with start_i=1.
  - RUN -> HALTED on the edge where limit_i!=0, freeze_i=0, clear_i=0 and cycle_o+1 == limit_i.
  - HALTED -> IDLE only on clear_i=1.
  - clear_i in RUN stays in RUN. start_i is ignored outside IDLE.
- Counting happens only on edges in RUN with freeze_i=0:
  - cycle_o increments by 1.
  - event counter k increments by 1 when event_i[k]=1.
  - The edge that enters HALTED still counts, so after halt cycle_o == limit_i exactly.
  - Nothing counts in IDLE or HALTED, or on the start edge itself.
- Overflow: an increment from all-ones sets ovf_o[k]=1 (sticky until clear or reset).
  - SATURATE=1: the value stays all-ones.
  - SATURATE=0: the value wraps to 0.
  - The cycle counter follows the same mode but has no flag.
- clear_i: next edge zeroes live counters and ovf_o; clear takes priority over increment. Shadows are not cleared.
- snap_i: next edge copies the pre-update live values (the values visible before that edge) into the shadows. snap_valid_o=1 on the following cycle only. snap_i together with clear_i captures the pre-clear values.
- HALTED auto-snapshot: entering HALTED performs an implicit snapshot of the post-increment values and pulses snap_valid_o.
- limit_i is sampled every edge. Changing it mid-run to a value <= cycle_o does not halt (equality compare only).
- Latency: event to live counter = 1 edge; snap_i to shadow = 1 edge; snap_valid_o arrives 1 cycle after capture.

Decomposition:
- Package perf_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2);
  - default CNT_W and NUM_EVT;
  - the channel index constants EVT_STALL=0, EVT_FLUSH=1, EVT_RETIRE=2, EVT_BRANCH=3.
- One sub-module, perf_evt_counter, implements a single channel:
  - parameters CNT_W and SATURATE;
  - ports clk_i, rst_i, en_i, inc_i, clr_i, cnt_o, ovf_o.
- Instantiate perf_evt_counter NUM_EVT times, plus once for the cycle counter (inc_i tied to 1, ovf unused).

Test Plan:
1. Start+limit: limit_i=30, start_i pulse, event_i[0]=1 every cycle, event_i[1]=1 on 5 cycles -> halt_o=1 after 30 counting edges; cycle_o=30; with sel_i=0 count_o=30; sel_i=1 -> 5; snap_valid_o pulses once; further events leave cycle_o and count_o unchanged.
2. Overflow, CNT_W=4: 20 event_i[2] strobes -> SATURATE=1 gives count 15, ovf_o[2]=1; SATURATE=0 gives count 4, ovf_o[2]=1; other channels ovf=0.
3. Freeze: run 10 cycles, freeze_i=1 for 5 cycles with events active, then 5 more cycles, snap -> snap_cycle_o=15 and event counts exclude the frozen cycles.
4. Simultaneous snap+clear at cycle_o=12 -> snap_cycle_o=12 and shadow values are pre-clear; the next cycle shows cycle_o=0 with state still RUN; ovf_o cleared.
5. Async reset mid-run at cycle_o=7, asserted between edges -> all outputs 0 and halt_o=0 immediately, before the next edge; after release, counting waits for start_i.
6. limit_i=0 unlimited: run 100 cycles -> halt_o stays 0 and cycle_o=100; clear_i in HALTED (from scenario 1) returns to IDLE with counters 0.

Source files
------------

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared encodings and defaults for the pipeline performance monitor
// Contents: FSM state encoding, default counter width and channel count,
// and the conventional event channel assignments used by the CPU core.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } perf_state_t;

  localparam int CNT_W_DEF   = 32;
  localparam int NUM_EVT_DEF = 4;

  localparam int EVT_STALL  = 0;
  localparam int EVT_FLUSH  = 1;
  localparam int EVT_RETIRE = 2;
  localparam int EVT_BRANCH = 3;

endpackage

// File: rtl/perf_evt_counter.sv
// rtl/perf_evt_counter.sv - single saturating/wrapping event counter with sticky overflow
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   en_i   counting window open (RUN and not frozen)
//   inc_i  increment request for this edge
//   clr_i  synchronous clear of count and overflow flag, wins over increment
//   cnt_o  live count
//   ovf_o  sticky overflow flag
module perf_evt_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i && inc_i) begin
      if (&cnt_o) begin
        // Incrementing from all-ones: flag it, then either hold or roll over.
        ovf_o <= 1'b1;
        cnt_o <= SATURATE ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - cycle/event performance monitor with limit halt and atomic snapshot
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   start_i              IDLE -> RUN
//   event_i              per-cycle event strobes, one per channel
//   freeze_i             suspends counting
//   clear_i              clears live counters and overflow flags; HALTED -> IDLE
//   snap_i               copies live counters into the shadows
//   limit_i              cycle limit, 0 = unlimited
//   sel_i                shadow channel select for count_o
//   count_o              selected shadow event count
//   snap_cycle_o         shadow cycle count
//   cycle_o              live cycle count
//   snap_valid_o         pulse in the cycle after a capture
//   halt_o               high in HALTED
//   ovf_o                sticky per-channel overflow flags
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVT  = NUM_EVT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit SATURATE = 1'b1,
  parameter int SEL_W    = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] event_i,
  input  logic               freeze_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   snap_cycle_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               snap_valid_o,
  output logic               halt_o,
  output logic [NUM_EVT-1:0] ovf_o
);

  perf_state_t      state_q, state_d;
  logic             count_en;
  logic             halt_entry;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] evt_cnt  [NUM_EVT];
  logic [CNT_W-1:0] shadow_q [NUM_EVT];
  logic [CNT_W-1:0] snap_cycle_q;
  logic             snap_valid_q;
  logic             ovf_w    [NUM_EVT];

  // Value a counter will hold after this edge when counting; used so the
  // halt snapshot can capture post-increment values on the same edge.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    if (!inc) return v;
    if (&v) return SATURATE ? v : '0;
    return v + 1'b1;
  endfunction

  assign count_en = (state_q == ST_RUN) && !freeze_i;

  // Equality only: moving the limit below the current count never halts.
  assign halt_entry = count_en && !clear_i && (limit_i != '0) &&
                      ((cycle_cnt + 1'b1) == limit_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i)    state_d = ST_RUN;
      ST_RUN:    if (halt_entry) state_d = ST_HALTED;
      ST_HALTED: if (clear_i)    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  perf_evt_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (count_en),
    .inc_i (1'b1),
    .clr_i (clear_i),
    .cnt_o (cycle_cnt),
    .ovf_o ()
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    perf_evt_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_evt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (count_en),
      .inc_i (event_i[k]),
      .clr_i (clear_i),
      .cnt_o (evt_cnt[k]),
      .ovf_o (ovf_w[k])
    );
  end

  // Halt capture takes the post-increment values; an explicit snap takes the
  // values visible before the edge (so snap with clear keeps pre-clear data).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_valid_q <= 1'b0;
      snap_cycle_q <= '0;
      for (int k = 0; k < NUM_EVT; k++) shadow_q[k] <= '0;
    end else begin
      snap_valid_q <= snap_i || halt_entry;
      if (halt_entry) begin
        snap_cycle_q <= bump(cycle_cnt, 1'b1);
        for (int k = 0; k < NUM_EVT; k++) shadow_q[k] <= bump(evt_cnt[k], event_i[k]);
      end else if (snap_i) begin
        snap_cycle_q <= cycle_cnt;
        for (int k = 0; k < NUM_EVT; k++) shadow_q[k] <= evt_cnt[k];
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (sel_i == SEL_W'(k)) count_o = shadow_q[k];
    end
  end

  always_comb begin
    ovf_o = '0;
    for (int k = 0; k < NUM_EVT; k++) ovf_o[k] = ovf_w[k];
  end

  assign snap_cycle_o = snap_cycle_q;
  assign cycle_o      = cycle_cnt;
  assign snap_valid_o = snap_valid_q;
  assign halt_o       = (state_q == ST_HALTED);

endmodule
